// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   FWD_*        forwarding-source encodings used by the fwd_* outputs
//   TW           width of Tuse/Tnew fields
//   md_state_t   mult/div timer state encoding
package pipe_pkg;

  localparam int unsigned TW = 2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// Mult/div busy timer.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   start       mult/div instruction is in E this cycle
//   is_div      1 = div/divu, 0 = mult/multu (valid with start)
//   busy        registered; high for exactly MULT_CYCLES/DIV_CYCLES cycles,
//               starting the cycle after start
module md_busy_timer
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  md_state_t      state;
  logic [CW-1:0]  md_cnt;

  // A start while already busy reloads the counter (restart wins).
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MD_IDLE;
      md_cnt <= '0;
    end else if (start) begin
      state  <= MD_BUSY;
      md_cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (state == MD_BUSY) begin
      md_cnt <= md_cnt - CW'(1);
      if (md_cnt == CW'(1)) begin
        state <= MD_IDLE;
      end
    end
  end

  assign busy = (state == MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
//   clk, reset              rising-edge clock, synchronous active-high reset
//   d_rs, d_rt              D-stage source registers, with Tuse d_tuse_rs/d_tuse_rt
//   d_is_md                 D holds mult/div/mfhi/mflo/mthi/mtlo
//   e_rs, e_rt, e_wa,e_tnew E-stage sources, destination and Tnew
//   e_md_start, e_md_is_div mult/div starting in E, and which kind
//   m_wa, m_tnew            M-stage destination and Tnew
//   w_wa                    W-stage destination (Tnew always 0)
//   stall, e_flush          hold PC/D and bubble E (combinational)
//   fwd_d_rs, fwd_d_rt      D operand source: RF / E / M
//   fwd_e_rs, fwd_e_rt      E operand source: pipe / M / W
//   md_busy                 mult/div unit busy (registered)
//   stall_cnt               count of stalled cycles since reset
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [TW-1:0]    d_tuse_rs,
  input  logic [TW-1:0]    d_tuse_rt,
  input  logic             d_is_md,
  input  logic [4:0]       e_rs,
  input  logic [4:0]       e_rt,
  input  logic [4:0]       e_wa,
  input  logic [TW-1:0]    e_tnew,
  input  logic             e_md_start,
  input  logic             e_md_is_div,
  input  logic [4:0]       m_wa,
  input  logic [TW-1:0]    m_tnew,
  input  logic [4:0]       w_wa,
  output logic             stall,
  output logic             e_flush,
  output logic [1:0]       fwd_d_rs,
  output logic [1:0]       fwd_d_rt,
  output logic [1:0]       fwd_e_rs,
  output logic [1:0]       fwd_e_rt,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic haz_rs, haz_rt, haz_md;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (e_md_start),
    .is_div (e_md_is_div),
    .busy   (md_busy)
  );

  // A producer only blocks D if its value arrives later than D needs it.
  always_comb begin
    haz_rs = (d_rs != 5'd0) &&
             (((d_rs == e_wa) && (e_tnew > d_tuse_rs)) ||
              ((d_rs == m_wa) && (m_tnew > d_tuse_rs)));
    haz_rt = (d_rt != 5'd0) &&
             (((d_rt == e_wa) && (e_tnew > d_tuse_rt)) ||
              ((d_rt == m_wa) && (m_tnew > d_tuse_rt)));
    haz_md = d_is_md && (md_busy || e_md_start);
    stall  = !reset && (haz_rs || haz_rt || haz_md);
  end

  assign e_flush = stall;

  // Nearest stage wins; $0 is never forwarded.
  always_comb begin
    fwd_d_rs = FWD_RF;
    if (d_rs != 5'd0) begin
      if ((d_rs == e_wa) && (e_tnew == '0))      fwd_d_rs = FWD_E;
      else if ((d_rs == m_wa) && (m_tnew == '0)) fwd_d_rs = FWD_M;
    end

    fwd_d_rt = FWD_RF;
    if (d_rt != 5'd0) begin
      if ((d_rt == e_wa) && (e_tnew == '0))      fwd_d_rt = FWD_E;
      else if ((d_rt == m_wa) && (m_tnew == '0)) fwd_d_rt = FWD_M;
    end

    fwd_e_rs = FWD_RF;
    if (e_rs != 5'd0) begin
      if ((e_rs == m_wa) && (m_tnew == '0)) fwd_e_rs = FWD_M;
      else if (e_rs == w_wa)                fwd_e_rs = FWD_W;
    end

    fwd_e_rt = FWD_RF;
    if (e_rt != 5'd0) begin
      if ((e_rt == m_wa) && (m_tnew == '0)) fwd_e_rt = FWD_M;
      else if (e_rt == w_wa)                fwd_e_rt = FWD_W;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
